systolic_mxu: RTL and testbench

SYSTOLIC_MXU -- requirements
Module: systolic_mxu

---
 rtl/systolic_pkg.sv | 19 +
 rtl/systolic_mxu_mac_pe.sv | 56 +++++
 rtl/systolic_mxu.sv | 110 +++++++++++
 tb/tb_systolic_mxu.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: FSM state type, counter width and the signed wrap/saturate add shared by systolic_mxu and mac_pe
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  localparam int CW = 4;
  typedef struct packed {
    logic ovf;
    logic signed [63:0] sum;
  } add_t;
  function automatic add_t sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int aw, input logic sat);
    logic signed [63:0] s, mx, mn;
    add_t r;
    s = a + b;
    mx = (64'sd1 <<< (aw - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    r.ovf = (s > mx) || (s < mn);
    r.sum = (sat && s > mx) ? mx : (sat && s < mn) ? mn : s;
    return r;
  endfunction
endpackage

// File: rtl/systolic_mxu_mac_pe.sv
// mac_pe: systolic PE; clk/reset, i_clr clears, i_en steps, i_a/i_b in, o_a/o_b forwarded, o_acc/o_ovf result
module mac_pe
  import systolic_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 32,
  parameter bit SAT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b,
  output logic [AW-1:0] o_acc,
  output logic          o_ovf
);
  logic [DW-1:0] r_a, r_b;
  logic signed [AW-1:0] r_acc;
  logic r_ovf, w_unused;
  logic signed [DW-1:0] w_sa, w_sb;
  logic signed [2*DW-1:0] w_prod;
  logic signed [63:0] w_p, w_acc;
  add_t w_res;
  assign w_sa = i_a;
  assign w_sb = i_b;
  assign w_prod = (2*DW)'(w_sa) * (2*DW)'(w_sb);
  assign w_p = 64'(w_prod);
  assign w_acc = 64'(r_acc);
  assign w_res = sat_add(w_acc, w_p, AW, SAT);
  assign w_unused = ^w_res.sum[63:AW];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_a <= i_a;
      r_b <= i_b;
      // once saturated the accumulator is pinned at its limit for the rest of the job
      r_acc <= (SAT && r_ovf) ? r_acc : w_res.sum[AW-1:0];
      r_ovf <= r_ovf | w_res.ovf;
    end
  assign o_a = r_a;
  assign o_b = r_b;
  assign o_acc = r_acc;
  assign o_ovf = r_ovf;
endmodule

// File: rtl/systolic_mxu.sv
// systolic_mxu: NxN output-stationary systolic matmul; valid/ready job in, matrix_A/matrix_B operands, y/overflow_flag/done/valid_out result
module systolic_mxu
  import systolic_pkg::*;
#(
  parameter int N = 4,
  parameter int DW = 8,
  parameter int AW = 32,
  parameter bit SAT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [N*N*DW-1:0] matrix_A,
  input  logic [N*N*DW-1:0] matrix_B,
  output logic [N*N*AW-1:0] y,
  output logic              overflow_flag,
  output logic              done,
  output logic              valid_out
);
  localparam logic [CW-1:0] FEED_LAST = CW'(2*N-2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((N > 1) ? N-2 : 0);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [N*N*DW-1:0] r_A, r_B;
  logic [N*N*AW-1:0] r_y, w_acc;
  logic [N*N-1:0] w_ovf;
  logic r_ovf, r_done, r_vout, w_accept, w_en, w_unused;
  logic [DW-1:0] w_a_in [N];
  logic [DW-1:0] w_b_in [N];
  logic [DW-1:0] w_ai [N][N];
  logic [DW-1:0] w_ao [N][N];
  logic [DW-1:0] w_bi [N][N];
  logic [DW-1:0] w_bo [N][N];
  assign ready = r_state == IDLE;
  assign w_accept = ready && valid;
  assign w_en = r_state == FEED || r_state == DRAIN;
  always_comb begin
    w_next = (r_state == IDLE) ? (valid ? FEED : IDLE)
           : (r_state == FEED) ? ((r_cnt == FEED_LAST) ? ((N > 1) ? DRAIN : DONE) : FEED)
           : (r_state == DRAIN) ? ((r_cnt == DRAIN_LAST) ? DONE : DRAIN)
           : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_en && w_next == r_state) ? r_cnt + 1'b1 : '0;
    end
  // skewed edge injection: row i sees A[i][t-i], column j sees B[t-j][j], zero outside the window
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_a_in[i] = '0;
      w_b_in[i] = '0;
      if (r_state == FEED && int'(r_cnt) >= i && int'(r_cnt) - i < N) begin
        w_a_in[i] = r_A[(i*N + int'(r_cnt) - i)*DW +: DW];
        w_b_in[i] = r_B[((int'(r_cnt) - i)*N + i)*DW +: DW];
      end
    end
  end
  // operands leaving the right column and bottom row are simply dropped
  always_comb begin
    w_unused = 1'b0;
    for (int i = 0; i < N; i++) w_unused = w_unused ^ (^w_ao[i][N-1]) ^ (^w_bo[N-1][i]);
  end
  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      assign w_ai[i][j] = (j == 0) ? w_a_in[i] : w_ao[i][(j == 0) ? 0 : j-1];
      assign w_bi[i][j] = (i == 0) ? w_b_in[j] : w_bo[(i == 0) ? 0 : i-1][j];
      mac_pe #(.DW(DW), .AW(AW), .SAT(SAT)) u_pe (
        .clk(clk),
        .reset(reset),
        .i_clr(w_accept),
        .i_en(w_en),
        .i_a(w_ai[i][j]),
        .i_b(w_bi[i][j]),
        .o_a(w_ao[i][j]),
        .o_b(w_bo[i][j]),
        .o_acc(w_acc[(i*N+j)*AW +: AW]),
        .o_ovf(w_ovf[i*N+j])
      );
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_A <= '0;
      r_B <= '0;
      r_y <= '0;
      r_ovf <= 1'b0;
      r_done <= 1'b0;
      r_vout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_A <= matrix_A;
        r_B <= matrix_B;
      end
      r_done <= r_state == DONE;
      if (r_state == DONE) begin
        r_y <= w_acc;
        r_ovf <= |w_ovf;
        r_vout <= 1'b1;
      end else if (r_state == FEED && r_cnt == '0) r_vout <= 1'b0;
    end
  assign y = r_y;
  assign overflow_flag = r_ovf;
  assign done = r_done;
  assign valid_out = r_vout;
endmodule

// File: tb/tb_systolic_mxu.sv
// tb_systolic_mxu: table-driven and randomized check of systolic_mxu against an arithmetic matmul model
module tb_systolic_mxu;
  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [511:0] y;
    logic ov;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, valid = 1'b0, valid1 = 1'b0;
  logic [127:0] ma = '0, mb = '0;
  logic [7:0] a1 = '0, b1 = '0;
  logic ready, ovf, done, vout, s_ready, s_ovf, s_done, s_vout, w_ready, w_ovf, w_done, w_vout;
  logic ready1, ovf1, done1, vout1;
  logic [511:0] y;
  logic [255:0] s_y, w_y;
  logic [31:0] y1;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  systolic_mxu #(.N(4), .DW(8), .AW(32), .SAT(0)) u_main (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .matrix_A(ma), .matrix_B(mb),
    .y(y), .overflow_flag(ovf), .done(done), .valid_out(vout));
  systolic_mxu #(.N(4), .DW(8), .AW(16), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .valid(valid), .ready(s_ready), .matrix_A(ma), .matrix_B(mb),
    .y(s_y), .overflow_flag(s_ovf), .done(s_done), .valid_out(s_vout));
  systolic_mxu #(.N(4), .DW(8), .AW(16), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .valid(valid), .ready(w_ready), .matrix_A(ma), .matrix_B(mb),
    .y(w_y), .overflow_flag(w_ovf), .done(w_done), .valid_out(w_vout));
  systolic_mxu #(.N(1), .DW(8), .AW(32), .SAT(0)) u_one (
    .clk(clk), .reset(reset), .valid(valid1), .ready(ready1), .matrix_A(a1), .matrix_B(b1),
    .y(y1), .overflow_flag(ovf1), .done(done1), .valid_out(vout1));
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // C = A*B element by element in k order, wrapping or saturating (and then holding) at aw bits
  task automatic model(input int n, input int aw, input bit sat, input logic [127:0] a, input logic [127:0] b,
                       output logic [511:0] yo, output logic ov);
    longint lim, mx, mn, acc, s;
    bit hold;
    yo = '0;
    ov = 1'b0;
    lim = 64'sd1 <<< aw;
    mx = lim / 2 - 1;
    mn = -(lim / 2);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        acc = 0;
        hold = 0;
        for (int k = 0; k < n; k++) begin
          s = acc + longint'($signed(a[(i*n+k)*8 +: 8])) * longint'($signed(b[(k*n+j)*8 +: 8]));
          if (s > mx || s < mn) ov = 1'b1;
          if (sat) begin
            if (!hold) begin
              if (s > mx) begin acc = mx; hold = 1; end
              else if (s < mn) begin acc = mn; hold = 1; end
              else acc = s;
            end
          end else acc = (s > mx) ? s - lim : (s < mn) ? s + lim : s;
        end
        for (int t = 0; t < aw; t++) yo[(i*n+j)*aw+t] = acc[t];
      end
  endtask
  task automatic job(input logic [127:0] a, input logic [127:0] b, output int cyc);
    @(negedge clk);
    ma = a;
    mb = b;
    valid = 1'b1;
    cyc = 0;
    while (!ready && cyc < 50) begin @(negedge clk); cyc++; end
    @(posedge clk);
    #1;
    valid = 1'b0;
    ma = ~a;
    mb = ~b;
    cyc = 1;
    while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
  endtask
  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    vec_t tbl [6];
    logic [511:0] ey, ey2, es, ew, idy;
    logic [127:0] ra, rb, ra2, rb2, ida;
    logic eo, eo2, eso, ewo;
    int cyc, busy, seen;
    for (int t = 0; t < 6; t++) begin
      tbl[t].a = '0; tbl[t].b = '0; tbl[t].y = '0; tbl[t].ov = 1'b0;
    end
    ida = '0; idy = '0;
    for (int i = 0; i < 4; i++) begin
      ida[(i*4+i)*8 +: 8] = 8'd1;
      idy[(i*4+i)*32 +: 32] = 32'd1;
    end
    tbl[0].a = ida;
    for (int e = 0; e < 16; e++) begin
      tbl[0].b[e*8 +: 8] = 8'(e + 1);
      tbl[0].y[e*32 +: 32] = 32'(e + 1);
      tbl[1].a[e*8 +: 8] = 8'hFF;
      tbl[1].b[e*8 +: 8] = 8'd127;
      tbl[1].y[e*32 +: 32] = 32'hFFFF_FE04;
      tbl[2].a[e*8 +: 8] = 8'h80;
      tbl[2].b[e*8 +: 8] = 8'h80;
      tbl[2].y[e*32 +: 32] = 32'h0001_0000;
    end
    for (int t = 3; t < 6; t++) begin
      tbl[t].a = {$urandom, $urandom, $urandom, $urandom};
      tbl[t].b = {$urandom, $urandom, $urandom, $urandom};
      model(4, 32, 0, tbl[t].a, tbl[t].b, tbl[t].y, tbl[t].ov);
    end
    repeat (2) @(negedge clk);
    chk("rst_y", y, 0); chk("rst_done", done, 0); chk("rst_vout", vout, 0); chk("rst_ovf", ovf, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1); chk("rst_ready1", ready1, 1); chk("rst_y1", y1, 0);
    for (int t = 0; t < 6; t++) begin
      job(tbl[t].a, tbl[t].b, cyc);
      chk($sformatf("v%0d_cyc", t), cyc, 12);
      chk($sformatf("v%0d_y", t), y, tbl[t].y);
      chk($sformatf("v%0d_ovf", t), ovf, tbl[t].ov);
      chk($sformatf("v%0d_vout", t), vout, 1);
      model(4, 16, 1, tbl[t].a, tbl[t].b, es, eso);
      model(4, 16, 0, tbl[t].a, tbl[t].b, ew, ewo);
      chk($sformatf("v%0d_sat_y", t), s_y, es);
      chk($sformatf("v%0d_sat_ovf", t), s_ovf, eso);
      chk($sformatf("v%0d_wrap_y", t), w_y, ew);
      chk($sformatf("v%0d_wrap_ovf", t), w_ovf, ewo);
      if (t == 2) begin
        chk("neg128_sat_y", s_y, {16{16'h7FFF}});
        chk("neg128_sat_ovf", s_ovf, 1);
        chk("neg128_wrap_y", w_y, 0);
        chk("neg128_wrap_ovf", w_ovf, 1);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse", t), done, 0);
      chk($sformatf("v%0d_hold_y", t), y, tbl[t].y);
      chk($sformatf("v%0d_hold_vout", t), vout, 1);
    end
    ra = {$urandom, $urandom, $urandom, $urandom}; rb = {$urandom, $urandom, $urandom, $urandom};
    ra2 = {$urandom, $urandom, $urandom, $urandom}; rb2 = {$urandom, $urandom, $urandom, $urandom};
    model(4, 32, 0, ra, rb, ey, eo);
    model(4, 32, 0, ra2, rb2, ey2, eo2);
    @(negedge clk);
    ma = ra; mb = rb; valid = 1'b1;
    @(posedge clk);
    #1;
    ma = ra2; mb = rb2;
    cyc = 1; busy = 0;
    while (!done && cyc < 100) begin
      if (ready) busy++;
      @(posedge clk); #1; cyc++;
    end
    chk("b2b_cyc1", cyc, 12); chk("b2b_busy_ready", busy, 0); chk("b2b_y1", y, ey); chk("b2b_ready", ready, 1);
    @(posedge clk);
    #1;
    chk("b2b_accepted", ready, 0); chk("b2b_vout_held", vout, 1); chk("b2b_y1_held", y, ey);
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("b2b_vout_drop", vout, 0);
    cyc = 2;
    while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("b2b_cyc2", cyc, 12); chk("b2b_y2", y, ey2); chk("b2b_ovf2", ovf, eo2);
    @(negedge clk);
    ma = ra; mb = rb; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_y", y, 0); chk("abort_vout", vout, 0); chk("abort_done", done, 0); chk("abort_ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (16) begin @(posedge clk); #1; if (done) seen++; end
    chk("abort_no_done", seen, 0);
    job(ida, ida, cyc);
    chk("abort_new_cyc", cyc, 12); chk("abort_new_y", y, idy);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      a1 = (t == 0) ? 8'd5 : 8'($urandom);
      b1 = (t == 0) ? 8'hFD : 8'($urandom);
      valid1 = 1'b1;
      model(1, 32, 0, {120'b0, a1}, {120'b0, b1}, ey, eo);
      @(posedge clk);
      #1;
      valid1 = 1'b0;
      cyc = 1;
      while (!done1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      chk($sformatf("n1_%0d_cyc", t), cyc, 3);
      chk($sformatf("n1_%0d_y", t), y1, ey);
      if (t == 0) chk("n1_minus15", y1, 32'hFFFF_FFF1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
